// File: rtl/qkd_sift_session_ctrl.sv
// Sequences one sifting session: core reset, raw-record streaming, done wait, QBER/yield verdict.
// Optional QKD_SESSION_STATS_EN adds saturating pass/abort session counters.
module qkd_sift_session_ctrl #(
    parameter int N_RAW        = 40,
    parameter int ADDR_W       = 10,
    parameter int MIN_SIFTED   = 8,
    parameter int QBER_MAX_PCT = 11,
    parameter int TIMEOUT_CYC  = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              manual_mode,
    output logic              raw_rd_en,
    output logic [ADDR_W-1:0] raw_rd_addr,
    input  logic [3:0]        raw_rd_data,
    output logic              sift_rst,
    output logic              sift_valid,
    output logic              sift_manual_mode,
    output logic              sift_alice_basis,
    output logic              sift_bob_basis,
    output logic              sift_alice_bit,
    output logic              sift_bob_bit,
    input  logic              sift_done,
    input  logic [ADDR_W-1:0] sift_qber_errors,
    input  logic [ADDR_W-1:0] sift_qber_total,
    output logic              busy,
    output logic              session_done,
    output logic              session_pass,
    output logic [1:0]        err_code,
    output logic [ADDR_W-1:0] res_errors,
    output logic [ADDR_W-1:0] res_total,
    output logic [15:0]       pass_cnt,
    output logic [15:0]       abort_cnt
);
    localparam int PW = ADDR_W + 7;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_RAW - 1);
    localparam logic [TW-1:0]     TO_LAST  = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FETCH, S_PUSH, S_WAIT, S_EVAL, S_REPORT
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              clr_q, clr_d;
    logic [TW-1:0]     wcnt_q, wcnt_d;
    logic              manual_q, manual_d;
    logic              pass_q, pass_d;
    logic [1:0]        err_q, err_d;
    logic [ADDR_W-1:0] res_err_q, res_err_d;
    logic [ADDR_W-1:0] res_tot_q, res_tot_d;
    logic [PW-1:0]     err_x100, tot_xmax;
    logic              push;

    // 17-bit products are wide enough for 1023*100 without overflow
    assign err_x100 = PW'(res_err_q) * PW'(100);
    assign tot_xmax = PW'(res_tot_q) * PW'(QBER_MAX_PCT);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        clr_d     = clr_q;
        wcnt_d    = wcnt_q;
        manual_d  = manual_q;
        pass_d    = pass_q;
        err_d     = err_q;
        res_err_d = res_err_q;
        res_tot_d = res_tot_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    manual_d  = manual_mode;
                    idx_d     = '0;
                    clr_d     = 1'b0;
                    pass_d    = 1'b0;
                    err_d     = 2'd0;
                    res_err_d = '0;
                    res_tot_d = '0;
                    state_d   = S_CLEAR;
                end
            end
            S_CLEAR: begin
                clr_d = 1'b1;
                if (clr_q) begin
                    addr_d  = idx_q;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_PUSH;
            S_PUSH: begin
                idx_d  = idx_q + ADDR_W'(1);
                wcnt_d = '0;
                if (idx_q == LAST_IDX) begin
                    state_d = S_WAIT;
                end else begin
                    addr_d  = idx_q + ADDR_W'(1);
                    state_d = S_FETCH;
                end
            end
            S_WAIT: begin
                // done has priority over a coincident timeout
                if (sift_done) begin
                    res_err_d = sift_qber_errors;
                    res_tot_d = sift_qber_total;
                    state_d   = S_EVAL;
                end else if (wcnt_q == TO_LAST) begin
                    err_d   = 2'd3;
                    state_d = S_REPORT;
                end else begin
                    wcnt_d = wcnt_q + TW'(1);
                end
            end
            S_EVAL: begin
                if (PW'(res_tot_q) < PW'(MIN_SIFTED)) begin
                    err_d = 2'd1;
                end else if (err_x100 > tot_xmax) begin
                    err_d = 2'd2;
                end else begin
                    err_d  = 2'd0;
                    pass_d = 1'b1;
                end
                state_d = S_REPORT;
            end
            S_REPORT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            addr_q    <= '0;
            clr_q     <= 1'b0;
            wcnt_q    <= '0;
            manual_q  <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= 2'd0;
            res_err_q <= '0;
            res_tot_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            addr_q    <= addr_d;
            clr_q     <= clr_d;
            wcnt_q    <= wcnt_d;
            manual_q  <= manual_d;
            pass_q    <= pass_d;
            err_q     <= err_d;
            res_err_q <= res_err_d;
            res_tot_q <= res_tot_d;
        end
    end

`ifdef QKD_SESSION_STATS_EN
    logic [15:0] pass_cnt_q, pass_cnt_d;
    logic [15:0] abort_cnt_q, abort_cnt_d;

    always_comb begin
        pass_cnt_d  = pass_cnt_q;
        abort_cnt_d = abort_cnt_q;
        if (state_q == S_REPORT) begin
            if (pass_q && pass_cnt_q != 16'hFFFF)
                pass_cnt_d = pass_cnt_q + 16'd1;
            if (!pass_q && abort_cnt_q != 16'hFFFF)
                abort_cnt_d = abort_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pass_cnt_q  <= '0;
            abort_cnt_q <= '0;
        end else begin
            pass_cnt_q  <= pass_cnt_d;
            abort_cnt_q <= abort_cnt_d;
        end
    end

    assign pass_cnt  = pass_cnt_q;
    assign abort_cnt = abort_cnt_q;
`else
    assign pass_cnt  = '0;
    assign abort_cnt = '0;
`endif

    assign push             = (state_q == S_PUSH);
    assign busy             = (state_q != S_IDLE);
    assign session_done     = (state_q == S_REPORT);
    assign raw_rd_en        = (state_q == S_FETCH);
    assign raw_rd_addr      = addr_q;
    // core stays in reset for the whole of rst, not just the CLEAR window
    assign sift_rst         = rst | (state_q == S_CLEAR);
    assign sift_valid       = push;
    assign sift_manual_mode = manual_q;
    assign sift_alice_basis = push & raw_rd_data[3];
    assign sift_bob_basis   = push & raw_rd_data[2];
    assign sift_alice_bit   = push & raw_rd_data[1];
    assign sift_bob_bit     = push & raw_rd_data[0];
    assign session_pass     = pass_q;
    assign err_code         = err_q;
    assign res_errors       = res_err_q;
    assign res_total        = res_tot_q;
endmodule

// File: tb/tb_qkd_sift_session_ctrl.sv
// Scoreboard bench: raw RAM and sifting-core models, per-record and per-session expectations.
module tb_qkd_sift_session_ctrl;
    localparam int N_RAW = 40;
    localparam int AW    = 10;
    localparam int TO    = 4096;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          manual_mode = 1'b0;
    logic          raw_rd_en;
    logic [AW-1:0] raw_rd_addr;
    logic [3:0]    raw_rd_data = 4'd0;
    logic          sift_rst, sift_valid, sift_manual_mode;
    logic          sift_alice_basis, sift_bob_basis;
    logic          sift_alice_bit, sift_bob_bit;
    logic          sift_done = 1'b0;
    logic [AW-1:0] sift_qber_errors = '0;
    logic [AW-1:0] sift_qber_total = '0;
    logic          busy, session_done, session_pass;
    logic [1:0]    err_code;
    logic [AW-1:0] res_errors, res_total;
    logic [15:0]   pass_cnt, abort_cnt;

    qkd_sift_session_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .manual_mode(manual_mode),
        .raw_rd_en(raw_rd_en), .raw_rd_addr(raw_rd_addr),
        .raw_rd_data(raw_rd_data), .sift_rst(sift_rst),
        .sift_valid(sift_valid), .sift_manual_mode(sift_manual_mode),
        .sift_alice_basis(sift_alice_basis), .sift_bob_basis(sift_bob_basis),
        .sift_alice_bit(sift_alice_bit), .sift_bob_bit(sift_bob_bit),
        .sift_done(sift_done), .sift_qber_errors(sift_qber_errors),
        .sift_qber_total(sift_qber_total), .busy(busy),
        .session_done(session_done), .session_pass(session_pass),
        .err_code(err_code), .res_errors(res_errors), .res_total(res_total),
        .pass_cnt(pass_cnt), .abort_cnt(abort_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    code;
        logic          pass;
        logic [AW-1:0] e;
        logic [AW-1:0] t;
    } exp_t;

    logic [3:0] mem [N_RAW];
    logic [3:0] rec_q [$];
    exp_t       res_q [$];
    int         n_chk = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         nv = 0;
    int         last_v = 0;
    int         ndone = 0;
    int         done_cyc = 0;
    int         start_cyc = 0;
    logic       exp_manual = 1'b0;
    bit         m_never = 1'b0;
    int         vcnt = 0;
    int         lat = 0;
    logic [3:0] r;
    exp_t       x;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk)
        if (raw_rd_en) raw_rd_data <= mem[raw_rd_addr];

    // core model: raises done a few cycles after the last record
    always @(posedge clk) begin
        if (sift_rst) begin
            vcnt      <= 0;
            lat       <= 0;
            sift_done <= 1'b0;
        end else if (sift_valid) begin
            vcnt <= vcnt + 1;
        end else if (vcnt == N_RAW && !m_never) begin
            if (lat < 3) lat <= lat + 1;
            else sift_done <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst && sift_valid) begin
            if (rec_q.size() == 0) begin
                chk("rec_extra", 1, 0);
            end else begin
                r = rec_q.pop_front();
                chk("rec", {sift_alice_basis, sift_bob_basis,
                            sift_alice_bit, sift_bob_bit}, r);
            end
            if (nv > 0) chk("spacing", cyc - last_v, 2);
            chk("manual", sift_manual_mode, exp_manual);
            nv++;
            last_v = cyc;
        end
        if (!rst && session_done) begin
            if (res_q.size() == 0) begin
                chk("done_extra", 1, 0);
            end else begin
                x = res_q.pop_front();
                chk("err_code", err_code, x.code);
                chk("pass", session_pass, x.pass);
                chk("res_err", res_errors, x.e);
                chk("res_tot", res_total, x.t);
            end
            ndone++;
            done_cyc = cyc;
        end
    end

    task automatic session(input int e, input int t, input bit never,
                           input bit man, input bit extra,
                           input logic [1:0] code);
        exp_t ex;
        int   d0;
        sift_qber_errors = AW'(e);
        sift_qber_total  = AW'(t);
        m_never    = never;
        exp_manual = man;
        for (int i = 0; i < N_RAW; i++) begin
            mem[i] = 4'($urandom_range(0, 15));
            rec_q.push_back(mem[i]);
        end
        ex.code = code;
        ex.pass = (code == 2'd0);
        ex.e    = never ? '0 : AW'(e);
        ex.t    = never ? '0 : AW'(t);
        res_q.push_back(ex);
        nv = 0;
        d0 = ndone;
        manual_mode = man;
        start = 1'b1;
        start_cyc = cyc;
        tick(1);
        start = 1'b0;
        manual_mode = 1'b0;
        for (int k = 0; k < TO + 300 && ndone == d0; k++) begin
            start = extra && (k == 30);
            tick(1);
        end
        start = 1'b0;
        chk("sess_done", ndone - d0, 1);
        chk("nvalid", nv, N_RAW);
        chk("last_lat", last_v - start_cyc, 2 + 2 * N_RAW);
        if (never) chk("to_lat", done_cyc - last_v, TO + 1);
        tick(1);
        chk("busy_after", busy, 0);
        if (extra) begin
            tick(100);
            chk("single_sess", ndone - d0, 1);
            chk("idle_after", busy, 0);
        end
    endtask

    initial begin
        int d0;
        logic [15:0] ep, ea;
        tick(2);
        chk("rst_busy", busy, 0);
        chk("rst_sift_rst", sift_rst, 1);
        chk("rst_done", session_done, 0);
        chk("rst_valid", sift_valid, 0);
        chk("rst_rd_en", raw_rd_en, 0);
        chk("rst_addr", raw_rd_addr, 0);
        chk("rst_code", err_code, 0);
        chk("rst_pass", session_pass, 0);
        chk("rst_cnts", {pass_cnt, abort_cnt}, 0);
        rst = 1'b0;
        tick(1);
        chk("rel_sift_rst", sift_rst, 0);

        session(2, 20, 0, 0, 0, 2'd0);
        session(3, 20, 0, 1, 0, 2'd2);
        session(11, 100, 0, 0, 0, 2'd0);
        session(0, 5, 0, 0, 0, 2'd1);
        session(0, 20, 1, 0, 0, 2'd3);
        session(1, 20, 0, 0, 1, 2'd0);

        // reset in the middle of record 17
        for (int i = 0; i < N_RAW; i++) rec_q.push_back(mem[i]);
        nv = 0;
        d0 = ndone;
        exp_manual = 1'b0;
        sift_qber_errors = AW'(1);
        sift_qber_total  = AW'(20);
        m_never = 1'b0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        for (int k = 0; k < 200 && nv < 17; k++) tick(1);
        chk("reach_17", nv, 17);
        rst = 1'b1;
        tick(1);
        chk("mid_busy", busy, 0);
        chk("mid_sift_rst", sift_rst, 1);
        chk("mid_pass", session_pass, 0);
        rst = 1'b0;
        rec_q.delete();
        tick(150);
        chk("mid_no_done", ndone - d0, 0);
        chk("mid_idle", busy, 0);
        chk("mid_res", {res_errors, res_total, err_code}, 0);
        chk("mid_cnts", {pass_cnt, abort_cnt}, 0);

        session(2, 20, 0, 0, 0, 2'd0);
        session(11, 100, 0, 0, 0, 2'd0);
        session(3, 20, 0, 0, 0, 2'd2);
        session(0, 20, 0, 1, 0, 2'd0);
        session(0, 5, 0, 0, 0, 2'd1);
`ifdef QKD_SESSION_STATS_EN
        ep = 16'd3;
        ea = 16'd2;
`else
        ep = 16'd0;
        ea = 16'd0;
`endif
        chk("pass_cnt", pass_cnt, ep);
        chk("abort_cnt", abort_cnt, ea);
        chk("q_empty", rec_q.size() + res_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
